// File: rtl/c1541_track_loader.sv
// Track buffer loader: fetches the D64 sectors of the current track into port B
// of the track RAM and writes drive-dirtied sectors back before the track is replaced.
module c1541_track_loader #(
  parameter int SETTLE = 65535
) (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        gcr_we,
  input  logic [4:0]  gcr_sector,
  output logic        ram_ready,
  output logic [9:0]  sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic [12:0] buf_addr,
  output logic [7:0]  buf_di,
  output logic        buf_we,
  input  logic [7:0]  buf_do
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_FLUSH, S_LOAD, S_READY} state_t;

  state_t      state_q;
  logic [16:0] cnt_q;
  logic [4:0]  sector_q;
  logic [20:0] dirty_q;
  logic [5:0]  loaded_track_q;
  logic [5:0]  target_q;
  logic [5:0]  trk_prev_q;
  logic        ram_ready_q;
  logic        sd_rd_q;
  logic        sd_wr_q;
  logic [9:0]  sd_lba_q;
  logic        busy_q;
  logic        ack_q;
  logic        mount_q;
  logic        buf_we_q;
  logic [12:0] buf_addr_q;
  logic [7:0]  buf_di_q;
  logic [4:0]  low_idx;
  logic        trk_valid;
  logic        mount_now;
  logic        ack_fall;

  function automatic logic [4:0] spt_of(input logic [5:0] t);
    if (t <= 6'd17)      return 5'd21;
    else if (t <= 6'd24) return 5'd19;
    else if (t <= 6'd30) return 5'd18;
    else                 return 5'd17;
  endfunction

  function automatic logic [9:0] start_of(input logic [5:0] t);
    logic [9:0] t10;
    t10 = {4'd0, t};
    if (t <= 6'd17)      return (t10 - 10'd1) * 10'd21;
    else if (t <= 6'd24) return 10'd357 + (t10 - 10'd18) * 10'd19;
    else if (t <= 6'd30) return 10'd490 + (t10 - 10'd25) * 10'd18;
    else                 return 10'd598 + (t10 - 10'd31) * 10'd17;
  endfunction

  always_comb begin
    low_idx = 5'd0;
    for (int i = 20; i >= 0; i--) begin
      if (dirty_q[i]) low_idx = 5'(i);
    end
  end

  assign trk_valid = (track >= 6'd1) && (track <= 6'd35);
  assign mount_now = img_mounted | mount_q;
  assign ack_fall  = ack_q & ~sd_ack;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      sector_q       <= '0;
      dirty_q        <= '0;
      loaded_track_q <= '0;
      target_q       <= '0;
      trk_prev_q     <= '0;
      ram_ready_q    <= 1'b0;
      sd_rd_q        <= 1'b0;
      sd_wr_q        <= 1'b0;
      sd_lba_q       <= '0;
      busy_q         <= 1'b0;
      ack_q          <= 1'b0;
      mount_q        <= 1'b0;
      buf_we_q       <= 1'b0;
      buf_addr_q     <= '0;
      buf_di_q       <= '0;
    end else begin
      buf_we_q   <= 1'b0;
      ack_q      <= sd_ack;
      trk_prev_q <= track;
      if (img_mounted) mount_q <= 1'b1;
      // Set even on the cycle READY is left, so that write still gets flushed.
      if (state_q == S_READY && gcr_we && !img_readonly && gcr_sector < spt_of(loaded_track_q))
        dirty_q <= dirty_q | (21'd1 << gcr_sector);

      case (state_q)
        S_IDLE: begin
          if (mount_now || (trk_valid && track != loaded_track_q)) begin
            if (mount_now) begin
              dirty_q        <= '0;
              loaded_track_q <= '0;
              mount_q        <= 1'b0;
            end
            state_q <= S_SETTLE;
            cnt_q   <= '0;
          end
        end

        S_SETTLE: begin
          if (mount_now) begin
            dirty_q        <= '0;
            loaded_track_q <= '0;
            mount_q        <= 1'b0;
            cnt_q          <= '0;
          end else if (!trk_valid) begin
            state_q <= S_IDLE;
          end else if (track != trk_prev_q) begin
            cnt_q <= '0;
          end else if (cnt_q == 17'(SETTLE)) begin
            target_q <= track;
            sector_q <= '0;
            state_q  <= (dirty_q != '0) ? S_FLUSH : S_LOAD;
          end else begin
            cnt_q <= cnt_q + 17'd1;
          end
        end

        S_FLUSH: begin
          if (busy_q) begin
            if (sd_ack) sd_wr_q <= 1'b0;
            if (ack_fall) begin
              busy_q  <= 1'b0;
              dirty_q <= dirty_q & ~(21'd1 << sector_q);
            end
          end else if (mount_now) begin
            dirty_q        <= '0;
            loaded_track_q <= '0;
            mount_q        <= 1'b0;
            state_q        <= S_SETTLE;
            cnt_q          <= '0;
          end else if (dirty_q == '0) begin
            sector_q <= '0;
            cnt_q    <= '0;
            state_q  <= (track != target_q) ? S_SETTLE : S_LOAD;
          end else begin
            sector_q <= low_idx;
            sd_lba_q <= start_of(loaded_track_q) + {5'd0, low_idx};
            sd_wr_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end

        S_LOAD: begin
          if (busy_q) begin
            if (sd_ack) sd_rd_q <= 1'b0;
            if (sd_ack && sd_buff_wr) begin
              buf_we_q   <= 1'b1;
              buf_addr_q <= {sector_q, sd_buff_addr};
              buf_di_q   <= sd_buff_dout;
            end
            if (ack_fall) begin
              busy_q   <= 1'b0;
              sector_q <= sector_q + 5'd1;
            end
          end else if (mount_now) begin
            dirty_q        <= '0;
            loaded_track_q <= '0;
            mount_q        <= 1'b0;
            state_q        <= S_SETTLE;
            cnt_q          <= '0;
          end else if (track != target_q) begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
          end else if (sector_q == spt_of(target_q)) begin
            loaded_track_q <= target_q;
            ram_ready_q    <= 1'b1;
            state_q        <= S_READY;
          end else begin
            sd_lba_q <= start_of(target_q) + {5'd0, sector_q};
            sd_rd_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end

        S_READY: begin
          if (mount_now) begin
            dirty_q        <= '0;
            loaded_track_q <= '0;
            mount_q        <= 1'b0;
            ram_ready_q    <= 1'b0;
            state_q        <= S_SETTLE;
            cnt_q          <= '0;
          end else if (track != loaded_track_q) begin
            ram_ready_q <= 1'b0;
            state_q     <= S_SETTLE;
            cnt_q       <= '0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The ready flag falls combinationally so the GCR stage never reads a stale track.
  assign ram_ready   = ram_ready_q & (track == loaded_track_q);
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_lba      = sd_lba_q;
  assign buf_we      = buf_we_q;
  assign buf_di      = buf_di_q;
  assign buf_addr    = (state_q == S_FLUSH && busy_q && sd_ack) ? {sector_q, sd_buff_addr} : buf_addr_q;
  assign sd_buff_din = (state_q == S_FLUSH) ? buf_do : 8'd0;

endmodule

// File: tb/tb_c1541_track_loader.sv
// Directed bench: host SD model, port-B track RAM model and GCR-side pokes.
module tb_c1541_track_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  track;
  logic        img_mounted, img_readonly, gcr_we;
  logic [4:0]  gcr_sector;
  logic        ram_ready;
  logic [9:0]  sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr, sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr;
  logic [12:0] buf_addr;
  logic [7:0]  buf_di, buf_do;
  logic        buf_we;

  logic [7:0]  mem [0:8191];
  logic        a_we;
  logic [12:0] a_addr;
  logic [7:0]  a_data;

  int checks = 0;
  int errors = 0;
  int last_lba, last_sum, req_lat;
  bit last_wr, ok;

  c1541_track_loader #(.SETTLE(16)) dut (
    .clk32(clk), .reset_n(reset_n), .track(track), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .gcr_we(gcr_we), .gcr_sector(gcr_sector),
    .ram_ready(ram_ready), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .buf_addr(buf_addr),
    .buf_di(buf_di), .buf_we(buf_we), .buf_do(buf_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_di;
    if (a_we)   mem[a_addr]   <= a_data;
    buf_do <= mem[buf_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int spt(input int t);
    if (t <= 17) return 21;
    if (t <= 24) return 19;
    if (t <= 30) return 18;
    return 17;
  endfunction

  function automatic int start(input int t);
    int s = 0;
    for (int k = 1; k < t; k++) s += spt(k);
    return s;
  endfunction

  function automatic logic [7:0] pat(input int lba, input int a);
    return 8'(lba * 7 + a * 3 + 1);
  endfunction

  function automatic logic [7:0] modb(input int s, input int a);
    return 8'(8'hA0 + s * 16 + a);
  endfunction

  function automatic int flush_sum(input int lba, input int s);
    int sum = 0;
    for (int a = 0; a < 256; a++) sum += (a + 1) * int'((a < 4) ? modb(s, a) : pat(lba, a));
    return sum;
  endfunction

  function automatic int mem_sum(input int s);
    int sum = 0;
    for (int a = 0; a < 256; a++) sum += (a + 1) * int'(mem[13'(s * 256 + a)]);
    return sum;
  endfunction

  function automatic int pat_sum(input int lba);
    int sum = 0;
    for (int a = 0; a < 256; a++) sum += (a + 1) * int'(pat(lba, a));
    return sum;
  endfunction

  // Serve one host transfer; optionally pulse img_mounted at byte mount_at.
  task automatic serve(input int mount_at);
    int n = 0;
    while (!(sd_rd || sd_wr) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      check("req_timeout", 0, 1);
      ok = 0;
      return;
    end
    check("rd_wr_excl", 32'(sd_rd & sd_wr), 0);
    req_lat  = n;
    last_wr  = sd_wr;
    last_lba = int'(sd_lba);
    last_sum = 0;
    sd_ack = 1'b1;
    @(negedge clk);
    check("req_drop", 32'(sd_rd | sd_wr), 0);
    for (int a = 0; a < 256; a++) begin
      sd_buff_addr = 8'(a);
      if (!last_wr) begin
        sd_buff_dout = pat(last_lba, a);
        sd_buff_wr   = 1'b1;
      end
      img_mounted = (a == mount_at);
      @(negedge clk);
      if (last_wr) last_sum += (a + 1) * int'(sd_buff_din);
    end
    img_mounted = 1'b0;
    sd_buff_wr  = 1'b0;
    sd_ack      = 1'b0;
    @(negedge clk);
    ok = 1;
  endtask

  task automatic load_track(input int t);
    int n;
    for (int s = 0; s < spt(t); s++) begin
      serve(-1);
      if (!ok) return;
      $display("load t=%0d sector=%0d lba=%0d wr=%0d", t, s, last_lba, last_wr);
      check("load_is_read", 32'(last_wr), 0);
      check("load_lba", last_lba, start(t) + s);
      if (s == 0) check("ready_low_in_load", 32'(ram_ready), 0);
    end
    n = 0;
    while (!ram_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ram_ready", 32'(ram_ready), 1);
    for (int s = 0; s < spt(t); s++) check("buf_data", mem_sum(s), pat_sum(start(t) + s));
  endtask

  task automatic gcr_touch(input int s);
    for (int a = 0; a < 4; a++) begin
      a_we = 1'b1; a_addr = 13'(s * 256 + a); a_data = modb(s, a);
      @(negedge clk);
    end
    a_we = 1'b0;
    gcr_sector = 5'(s); gcr_we = 1'b1;
    @(negedge clk);
    gcr_we = 1'b0;
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, n;
    reset_n = 1'b0; track = 6'd18; img_mounted = 1'b0; img_readonly = 1'b0;
    gcr_we = 1'b0; gcr_sector = '0; sd_ack = 1'b0; sd_buff_addr = '0;
    sd_buff_dout = '0; sd_buff_wr = 1'b0; a_we = 1'b0; a_addr = '0; a_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sd_rd", 32'(sd_rd), 0);
    check("rst_sd_wr", 32'(sd_wr), 0);
    check("rst_ram_ready", 32'(ram_ready), 0);
    check("rst_sd_lba", 32'(sd_lba), 0);
    check("rst_buf_we", 32'(buf_we), 0);
    check("rst_buf_addr", 32'(buf_addr), 0);
    reset_n = 1'b1;

    // Track 18 from reset
    load_track(18);

    // Track 1, dirty sectors 3 then 0, step to track 2
    track = 6'd1;
    load_track(1);
    gcr_touch(3);
    gcr_touch(0);
    track = 6'd2;
    #1;
    check("ready_drop_now", 32'(ram_ready), 0);
    serve(-1);
    $display("flush lba=%0d wr=%0d sum=%0d", last_lba, last_wr, last_sum);
    check("flush0_wr", 32'(last_wr), 1);
    check("flush0_lba", last_lba, 0);
    check("flush0_data", last_sum, flush_sum(0, 0));
    serve(-1);
    $display("flush lba=%0d wr=%0d sum=%0d", last_lba, last_wr, last_sum);
    check("flush1_wr", 32'(last_wr), 1);
    check("flush1_lba", last_lba, 3);
    check("flush1_data", last_sum, flush_sum(3, 3));
    load_track(2);

    // Rapid stepping 1 -> 2 -> 3: only track 3 loads
    seen = 0;
    track = 6'd1;
    repeat (8) begin @(negedge clk); if (sd_rd || sd_wr) seen++; end
    track = 6'd2;
    repeat (8) begin @(negedge clk); if (sd_rd || sd_wr) seen++; end
    track = 6'd3;
    check("no_req_while_stepping", seen, 0);
    load_track(3);

    // Last track
    track = 6'd35;
    load_track(35);

    // Write-protected pokes and out-of-range sectors leave nothing to flush
    img_readonly = 1'b1;
    gcr_touch(2);
    img_readonly = 1'b0;
    gcr_touch(17);
    gcr_touch(20);
    track = 6'd34;
    load_track(34);

    // Mount while dirty, then mount again during sector 5 of the reload
    gcr_touch(1);
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
    @(negedge clk);
    check("mount_ready_drop", 32'(ram_ready), 0);
    for (int s = 0; s < 6; s++) begin
      serve((s == 5) ? 100 : -1);
      $display("reload sector=%0d lba=%0d wr=%0d", s, last_lba, last_wr);
      check("mount_is_read", 32'(last_wr), 0);
      check("mount_lba", last_lba, start(34) + s);
    end
    load_track(34);

    // Asynchronous reset during an outstanding request
    track = 6'd33;
    n = 0;
    while (!sd_rd && n < 100) begin @(negedge clk); n++; end
    check("rst_req_seen", 32'(sd_rd), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_rd", 32'(sd_rd), 0);
    check("rst_mid_ready", 32'(ram_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
